// File: rtl/cordic_pkg.sv
// Shared constants and types for the pipelined CORDIC cosine unit.
// All fixed-point values are signed Q2.30.
package cordic_pkg;

    localparam int CORDIC_ITERS = 24;
    localparam int LATENCY      = 26;

    typedef logic signed [31:0] q2_30_t;

    localparam q2_30_t K_GAIN    = 32'h26DD3B6A;
    localparam q2_30_t SAT_ANGLE = 32'h40000000;

    // atan(2^-i), rounded to nearest
    localparam q2_30_t ATAN_ROM [CORDIC_ITERS] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080
    };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation (rotation mode) for iteration ITER.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int ITER = 0
) (
    input  logic   clk_sys,
    input  logic   rst,
    input  q2_30_t x_in,
    input  q2_30_t y_in,
    input  q2_30_t z_in,
    output q2_30_t x_out,
    output q2_30_t y_out,
    output q2_30_t z_out
);

    q2_30_t x_sh;
    q2_30_t y_sh;

    assign x_sh = x_in >>> ITER;
    assign y_sh = y_in >>> ITER;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else if (!z_in[31]) begin
            x_out <= x_in - y_sh;
            y_out <= y_in + x_sh;
            z_out <= z_in - ATAN_ROM[ITER];
        end else begin
            x_out <= x_in + y_sh;
            y_out <= y_in - x_sh;
            z_out <= z_in + ATAN_ROM[ITER];
        end
    end

endmodule

// File: rtl/cordic2_cos.sv
// Fully pipelined cosine: float angle -> Q2.30, 24 CORDIC stages, Q2.30 -> float.
// Fixed 26-cycle latency, one sample per clock, no handshake.
module cordic2_cos
    import cordic_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [31:0] theta,
    output logic [31:0] result
);

    logic [30:0] theta_q;
    logic        theta_vld;
    logic [7:0]  exp_f;
    logic [7:0]  shamt;
    q2_30_t      z_conv;
    q2_30_t      x0_q;
    q2_30_t      z0_q;
    q2_30_t      xs [CORDIC_ITERS+1];
    q2_30_t      ys [CORDIC_ITERS+1];
    q2_30_t      zs [CORDIC_ITERS+1];
    q2_30_t      x_fin;
    logic        unused_tail;

    // cos is even, so the sign bit is never captured
    assign exp_f = theta_q[30:23];

    always_comb begin
        shamt  = 8'd127 - exp_f;
        z_conv = '0;
        if (exp_f >= 8'd127) begin
            z_conv = SAT_ANGLE;
        end else if (exp_f >= 8'd97) begin
            z_conv = {2'b01, theta_q[22:0], 7'b0} >> shamt;
        end
    end

    // theta_vld keeps the cleared input register from launching a cos(0) bubble
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            theta_q   <= '0;
            theta_vld <= 1'b0;
            x0_q      <= '0;
            z0_q      <= '0;
        end else begin
            theta_q   <= theta[30:0];
            theta_vld <= 1'b1;
            x0_q      <= theta_vld ? K_GAIN : '0;
            z0_q      <= z_conv;
        end
    end

    assign xs[0] = x0_q;
    assign ys[0] = '0;
    assign zs[0] = z0_q;

    generate
        for (genvar i = 0; i < CORDIC_ITERS; i++) begin : g_stage
            cordic_stage #(.ITER(i)) u_stage (
                .clk_sys (clk_sys),
                .rst     (rst),
                .x_in    (xs[i]),
                .y_in    (ys[i]),
                .z_in    (zs[i]),
                .x_out   (xs[i+1]),
                .y_out   (ys[i+1]),
                .z_out   (zs[i+1])
            );
        end
    endgenerate

    assign x_fin = xs[CORDIC_ITERS];

    // final sine, residual angle and sub-LSB bits of x are not part of the result
    assign unused_tail = ^{ys[CORDIC_ITERS], zs[CORDIC_ITERS], x_fin[31], x_fin[5:0], theta[31]};

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (x_fin[30]) begin
            result <= {1'b0, 8'd127, x_fin[29:7]};
        end else if (x_fin[29]) begin
            result <= {1'b0, 8'd126, x_fin[28:6]};
        end else begin
            result <= '0;
        end
    end

endmodule

// File: tb/tb_cordic2_cos.sv
// Directed bench for cordic2_cos: reset behaviour, a vector stream, exact latency
// and a mid-stream reset, with expectations hand-computed as IEEE-754 singles.
module tb_cordic2_cos;
    import cordic_pkg::*;

    typedef struct {
        logic [31:0] theta;
        logic [31:0] expv;
        int          tol;
    } vec_t;

    localparam int NVEC = 14;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] theta;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    vec_t        vecs [NVEC];
    logic [31:0] got  [NVEC];

    always #5 clk_sys = ~clk_sys;

    cordic2_cos dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .theta   (theta),
        .result  (result)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_ulp(input string name, input logic [31:0] act,
                             input logic [31:0] expv, input int tol);
        longint d;
        checks++;
        d = longint'(act) - longint'(expv);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            failures++;
            $display("FAIL %s: result=%08h expected=%08h (tol %0d ulp)", name, act, expv, tol);
        end
    endtask

    // caller holds rst high; release it with th applied and follow the first sample out
    task automatic run_after_reset(input string name, input logic [31:0] th,
                                   input logic [31:0] expv);
        theta = th;
        rst   = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            tick();
            check_ulp($sformatf("%s_zero%0d", name, k), result, 32'h0, 0);
        end
        tick();
        check_ulp($sformatf("%s_first", name), result, expv, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00000000, 32'h3F800000, 8};  // 0.0
        vecs[1]  = '{32'h3E800000, 32'h3F780AA4, 8};  // 0.25
        vecs[2]  = '{32'h3F000000, 32'h3F60A940, 8};  // 0.5
        vecs[3]  = '{32'h3F400000, 32'h3F3B4FF6, 8};  // 0.75
        vecs[4]  = '{32'h3F800000, 32'h3F0A5140, 8};  // 1.0
        vecs[5]  = '{32'hBF000000, 32'h3F60A940, 8};  // -0.5
        vecs[6]  = '{32'h40000000, 32'h3F0A5140, 8};  // 2.0 saturates
        vecs[7]  = '{32'h7FC00000, 32'h3F0A5140, 8};  // NaN saturates
        vecs[8]  = '{32'h7F800000, 32'h3F0A5140, 8};  // +Inf saturates
        vecs[9]  = '{32'hBF7F0000, 32'h3F0B2866, 8};  // -0.99609375
        vecs[10] = '{32'h30000000, 32'h3F800000, 8};  // exp 96, flushed
        vecs[11] = '{32'h00000001, 32'h3F800000, 8};  // denormal
        vecs[12] = '{32'hBF800000, 32'h3F0A5140, 8};  // -1.0
        vecs[13] = '{32'h30800000, 32'h3F800000, 8};  // exp 97, z = 1 LSB

        rst   = 1'b1;
        theta = 32'hBF7F0000;
        repeat (3) tick();
        check_ulp("reset_hold", result, 32'h0, 0);
        run_after_reset("release", 32'hBF7F0000, 32'h3F0B2866);

        // back-to-back stream: sample set in iteration c emerges after iteration c+26
        for (int c = 0; c < NVEC + 26; c++) begin
            theta = (c < NVEC) ? vecs[c].theta : 32'h40000000;
            tick();
            if (c >= 26) begin
                got[c-26] = result;
                check_ulp($sformatf("vec%0d", c - 26), result, vecs[c-26].expv, vecs[c-26].tol);
            end
        end
        check_ulp("even_symmetry", got[5], got[2], 0);
        check_ulp("sat_2p0_vs_1p0", got[6], got[4], 0);
        check_ulp("sat_nan_vs_1p0", got[7], got[4], 0);

        // single 0.0 sample inside a cos(1) background lands on exactly one cycle
        theta = 32'h40000000;
        repeat (LATENCY + 2) tick();
        theta = 32'h00000000;
        tick();
        theta = 32'h40000000;
        repeat (LATENCY - 1) tick();
        check_ulp("lat_early", result, 32'h3F0A5140, 8);
        tick();
        check_ulp("lat_exact", result, 32'h3F800000, 8);
        tick();
        check_ulp("lat_late", result, 32'h3F0A5140, 8);

        // one-cycle reset with 0.5 samples in flight
        theta = 32'h3F000000;
        repeat (LATENCY + 4) tick();
        check_ulp("pre_reset_full", result, 32'h3F60A940, 8);
        rst = 1'b1;
        #1;
        check_ulp("async_clear", result, 32'h0, 0);
        tick();
        check_ulp("reset_edge", result, 32'h0, 0);
        run_after_reset("midreset", 32'h3F800000, 32'h3F0A5140);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
